// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier.
//   state_e       : controller states (idle, iterating, result cycle)
//   MODE_UNSIGNED : sel value selecting unsigned operands
//   MODE_SIGNED   : sel value selecting two's-complement operands
package mul_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/mul_abs.sv
// Parametrised conditional two's-complement negate.
// Ports:
//   value  : input operand
//   negate : when high, result = -value, otherwise result = value
//   result : output, same width as value
module mul_abs #(
  parameter int unsigned Width = 6
) (
  input  logic [Width-1:0] value,
  input  logic             negate,
  output logic [Width-1:0] result
);

  always_comb begin
    result = negate ? (~value + Width'(1)) : value;
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle, with run-time
// unsigned/signed mode. Operands are reduced to magnitudes at load, multiplied as
// unsigned numbers, and the sign is restored on writeback.
// Optional feature: define MUL_SEQ_EARLY_EXIT_EN to stop iterating as soon as the
// remaining multiplier bits are all zero.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, sampled in IDLE or DONE
//   sel   : 0 unsigned, 1 signed; captured with start
//   a, b  : multiplicand / multiplier, captured with start
//   busy  : high while iterating
//   done  : one-cycle pulse when out is updated
//   out   : product, held until the next completion or reset
module mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sel,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] out_q, out_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] acc_sum, acc_signed;
  logic               last_iter;

  mul_abs #(.Width(WIDTH)) u_abs_a (
    .value  (a),
    .negate (sel & a[WIDTH-1]),
    .result (abs_a)
  );

  mul_abs #(.Width(WIDTH)) u_abs_b (
    .value  (b),
    .negate (sel & b[WIDTH-1]),
    .result (abs_b)
  );

  // Writeback sees the accumulator including the final iteration's add.
  mul_abs #(.Width(2*WIDTH)) u_abs_out (
    .value  (acc_sum),
    .negate (neg_q),
    .result (acc_signed)
  );

  always_comb begin
    acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`ifdef MUL_SEQ_EARLY_EXIT_EN
    last_iter = (cnt_q == CntW'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    last_iter = (cnt_q == CntW'(WIDTH - 1));
`endif
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    out_d    = out_q;

    unique case (state_q)
      StRun: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (last_iter) begin
          out_d   = acc_signed;
          state_d = StDone;
        end
      end
      StIdle, StDone: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          mplier_d = abs_b;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = (sel == MODE_SIGNED) & (a[WIDTH-1] ^ b[WIDTH-1]);
          state_d  = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      out_q    <= out_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign out  = out_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq (WIDTH=6): directed corners, back-to-back
// operation, start during RUN, mid-run reset and random operands against an
// arithmetic reference model. Honours MUL_SEQ_EARLY_EXIT_EN for expected latency.
module tb_mul_seq;

  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           sel;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] out;

  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] last_out;

  mul_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sel   (sel),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  // Product by plain integer arithmetic, truncated to the product width.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    longint xv, yv, p;
    xv = s ? longint'($signed(x)) : longint'({1'b0, x});
    yv = s ? longint'($signed(y)) : longint'({1'b0, y});
    p  = xv * yv;
    return p[2*W-1:0];
  endfunction

  function automatic int ref_lat(input logic [W-1:0] y, input logic s);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    int mag, hi;
    mag = (s && y[W-1]) ? (1 << W) - int'(y) : int'(y);
    hi  = 0;
    for (int i = 0; i < W; i++) if (mag[i]) hi = i;
    return hi + 1;
`else
    return W;
`endif
  endfunction

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation; optionally pulses start with junk operands during RUN.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts,
                       input bit glitch, input string tag);
    int n, bcnt, lat;
    logic [2*W-1:0] exp;
    exp = ref_mul(ta, tbv, ts);
    lat = ref_lat(tbv, ts);
    @(negedge clk);
    start = 1'b1; a = ta; b = tbv; sel = ts;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); sel = 1'($urandom);
    chk(32'(out), 32'(last_out), {tag, "_out_held"});
    n = 0; bcnt = 0;
    while (!done && n < 40) begin
      if (busy) bcnt++;
      start = glitch && (n == 1);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk(32'(done), 32'd1, {tag, "_done"});
    chk(32'(n), 32'(lat), {tag, "_latency"});
    chk(32'(bcnt), 32'(lat), {tag, "_busy_cycles"});
    chk(32'(busy), 32'd0, {tag, "_busy_at_done"});
    chk(32'(out), 32'(exp), {tag, "_product"});
    @(posedge clk); #1;
    chk(32'(done), 32'd0, {tag, "_done_pulse"});
    chk(32'(out), 32'(exp), {tag, "_out_hold"});
    last_out = exp;
  endtask

  initial begin
    int n, dcnt;
    logic [W-1:0] ca, cb;
    logic cs;

    rst = 1'b1; start = 1'b0; sel = 1'b0; a = '0; b = '0;
    last_out = '0;
    repeat (2) @(posedge clk);
    #1;
    chk(32'(busy), 32'd0, "reset_busy");
    chk(32'(done), 32'd0, "reset_done");
    chk(32'(out), 32'd0, "reset_out");
    @(negedge clk); rst = 1'b0;

    // Directed cases.
    do_op(6'b111101, 6'd5, 1'b1, 1'b0, "neg3x5");
    chk(32'(out), 32'h0FF1, "neg3x5_const");
    do_op(6'd63, 6'd63, 1'b0, 1'b0, "u63x63");
    chk(32'(out), 32'h0F81, "u63x63_const");
    do_op(6'd63, 6'd63, 1'b1, 1'b0, "s63x63");
    chk(32'(out), 32'h0001, "s63x63_const");
    do_op(6'b100000, 6'b100000, 1'b1, 1'b0, "min_x_min");
    chk(32'(out), 32'h0400, "min_x_min_const");
    do_op(6'b100000, 6'd31, 1'b1, 1'b0, "min_x_max");
    chk(32'(out), 32'h0C20, "min_x_max_const");
    do_op(6'd0, 6'b111111, 1'b1, 1'b0, "zero_x_m1");
    do_op(6'd17, 6'd1, 1'b0, 1'b0, "b_one");
    do_op(6'd42, 6'd0, 1'b0, 1'b0, "b_zero");
    do_op(6'd11, 6'b000100, 1'b0, 1'b0, "b_four");

    // start pulse during RUN must be ignored.
    do_op(6'd23, 6'd45, 1'b0, 1'b1, "glitch_u");
    do_op(6'b110011, 6'd29, 1'b1, 1'b1, "glitch_s");

    // Back-to-back with start held high; new operands presented at each done.
    @(negedge clk);
    ca = W'($urandom); cb = W'($urandom); cs = 1'($urandom);
    start = 1'b1; a = ca; b = cb; sel = cs;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!done && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      chk(32'(n), 32'(ref_lat(cb, cs)), $sformatf("b2b%0d_latency", i));
      chk(32'(out), 32'(ref_mul(ca, cb, cs)), $sformatf("b2b%0d_product", i));
      last_out = ref_mul(ca, cb, cs);
      if (i < 3) begin
        ca = W'($urandom); cb = W'($urandom); cs = 1'($urandom);
        a = ca; b = cb; sel = cs;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (i < 3) chk(32'(busy), 32'd1, $sformatf("b2b%0d_reload", i));
    end
    chk(32'(busy), 32'd0, "b2b_idle_busy");
    chk(32'(done), 32'd0, "b2b_idle_done");

    // Reset in the third RUN cycle abandons the operation.
    @(negedge clk);
    start = 1'b1; a = 6'd37; b = 6'd61; sel = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk(32'(busy), 32'd0, "rst_busy");
    chk(32'(done), 32'd0, "rst_done");
    chk(32'(out), 32'd0, "rst_out");
    rst = 1'b0;
    last_out = '0;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk(32'(dcnt), 32'd0, "rst_no_done");
    do_op(6'd37, 6'd61, 1'b0, 1'b0, "after_rst");

    // Random operands.
    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
